// File: rtl/ulvds_rx_deser.sv
// ULVDS receive deserializer: double-flops the I/IB pair, hunts for the framing
// word, then shifts out fixed-width words MSB first into a one-deep output buffer.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | line undriven or receiver disabled; waiting for a valid bit
// S_HUNT | shifting valid bits, looking for SYNC on a bit boundary
// S_DATA | word-aligned; every WIDTH valid bits form one output word
module ulvds_rx_deser #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] SYNC     = WIDTH'(8'hA5),
    parameter int               IDLE_CYC = 4
) (
    input  logic             C,
    input  logic             RB,
    input  logic             I,
    input  logic             IB,
    input  logic             EN,
    input  logic             DR,
    output logic [WIDTH-1:0] DO,
    output logic             DV,
    output logic             LOCK,
    output logic             IDLE,
    output logic             ERR
);

    localparam int VCW = $clog2(WIDTH + 1);
    localparam int BCW = $clog2(WIDTH);
    localparam int ICW = $clog2(IDLE_CYC + 1);

    localparam logic [VCW-1:0] V_FULL = VCW'(WIDTH);
    localparam logic [BCW-1:0] B_LAST = BCW'(WIDTH - 1);
    localparam logic [ICW-1:0] I_SAT  = ICW'(IDLE_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HUNT = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             s1_i, s1_ib, s2_i, s2_ib;
    logic [WIDTH-1:0] sr, sr_nxt, sr_shift;
    logic [VCW-1:0]   vcnt, vcnt_nxt, vcnt_inc;
    logic [BCW-1:0]   bcnt, bcnt_nxt;
    logic [ICW-1:0]   inv_cnt, inv_nxt;
    logic [WIDTH-1:0] do_q, do_nxt;
    logic             dv_q, dv_nxt;
    logic             err_q, err_nxt;
    logic             samp_valid;
    logic             push, frame_err, ovf;

    always_comb begin
        // An X/Z on either leg makes the XOR non-1, so it counts as undriven.
        samp_valid = ((s2_i ^ s2_ib) == 1'b1);
        sr_shift   = {sr[WIDTH-2:0], s2_i};
        vcnt_inc   = (vcnt == V_FULL) ? V_FULL : vcnt + 1'b1;
        if (samp_valid)
            inv_nxt = '0;
        else if (inv_cnt == I_SAT)
            inv_nxt = I_SAT;
        else
            inv_nxt = inv_cnt + 1'b1;

        state_nxt = state;
        sr_nxt    = sr;
        vcnt_nxt  = vcnt;
        bcnt_nxt  = bcnt;
        push      = 1'b0;
        frame_err = 1'b0;

        if (!EN) begin
            state_nxt = S_IDLE;
            sr_nxt    = '0;
            vcnt_nxt  = '0;
            bcnt_nxt  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (samp_valid) begin
                        sr_nxt    = sr_shift;
                        vcnt_nxt  = VCW'(1);
                        state_nxt = S_HUNT;
                    end
                end
                S_HUNT: begin
                    if (samp_valid) begin
                        sr_nxt   = sr_shift;
                        vcnt_nxt = vcnt_inc;
                        if (vcnt_inc == V_FULL && sr_shift == SYNC) begin
                            state_nxt = S_DATA;
                            bcnt_nxt  = '0;
                        end
                    end else begin
                        vcnt_nxt = '0;
                        if (inv_nxt == I_SAT)
                            state_nxt = S_IDLE;
                    end
                end
                S_DATA: begin
                    if (samp_valid) begin
                        sr_nxt = sr_shift;
                        if (bcnt == B_LAST) begin
                            push     = 1'b1;
                            bcnt_nxt = '0;
                        end else begin
                            bcnt_nxt = bcnt + 1'b1;
                        end
                    end else begin
                        state_nxt = S_HUNT;
                        frame_err = 1'b1;
                        sr_nxt    = '0;
                        vcnt_nxt  = '0;
                        bcnt_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    sr_nxt    = '0;
                    vcnt_nxt  = '0;
                    bcnt_nxt  = '0;
                end
            endcase
        end

        // A full buffer being drained on this edge can take the new word directly.
        do_nxt = do_q;
        dv_nxt = dv_q;
        ovf    = 1'b0;
        if (push) begin
            if (!dv_q || DR) begin
                do_nxt = sr_shift;
                dv_nxt = 1'b1;
            end else begin
                ovf = 1'b1;
            end
        end else if (dv_q && DR) begin
            dv_nxt = 1'b0;
        end

        err_nxt = EN ? (err_q | frame_err | ovf) : 1'b0;
    end

    always_ff @(posedge C) begin
        if (!RB) begin
            s1_i    <= 1'b0;
            s1_ib   <= 1'b0;
            s2_i    <= 1'b0;
            s2_ib   <= 1'b0;
            state   <= S_IDLE;
            sr      <= '0;
            vcnt    <= '0;
            bcnt    <= '0;
            inv_cnt <= '0;
            do_q    <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_i    <= I;
            s1_ib   <= IB;
            s2_i    <= s1_i;
            s2_ib   <= s1_ib;
            state   <= state_nxt;
            sr      <= sr_nxt;
            vcnt    <= vcnt_nxt;
            bcnt    <= bcnt_nxt;
            inv_cnt <= inv_nxt;
            do_q    <= do_nxt;
            dv_q    <= dv_nxt;
            err_q   <= err_nxt;
        end
    end

    assign DO   = do_q;
    assign DV   = dv_q;
    assign LOCK = (state == S_DATA);
    assign IDLE = (state == S_IDLE);
    assign ERR  = err_q;

endmodule

// File: tb/tb_ulvds_rx_deser.sv
// Scoreboard bench for ulvds_rx_deser: expected words are queued as they are
// serialized and compared whenever a DV/DR transfer happens.
module tb_ulvds_rx_deser;

    logic       C = 1'b0;
    logic       RB, I, IB, EN, DR;
    logic [7:0] DO;
    logic       DV, LOCK, IDLE, ERR;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb_q[$];

    ulvds_rx_deser #(.WIDTH(8), .SYNC(8'hA5), .IDLE_CYC(4)) dut (
        .C(C), .RB(RB), .I(I), .IB(IB), .EN(EN), .DR(DR),
        .DO(DO), .DV(DV), .LOCK(LOCK), .IDLE(IDLE), .ERR(ERR)
    );

    always #5 C = ~C;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs settle 2ns after the rising edge; the negedge view therefore shows
    // exactly what the next rising edge will act on.
    always @(negedge C) begin
        if (RB === 1'b1 && DV === 1'b1 && DR === 1'b1) begin
            if (sb_q.size() == 0)
                chk("dv_spurious", {31'd0, DV}, 32'd0);
            else
                chk("do_word", {24'd0, DO}, {24'd0, sb_q.pop_front()});
        end
    end

    task automatic drive(input logic i, input logic ib);
        @(posedge C);
        #2;
        I  = i;
        IB = ib;
    endtask

    task automatic send_bits(input logic [7:0] w, input int hi, input int lo);
        for (int k = hi; k >= lo; k--)
            drive(w[k], ~w[k]);
    endtask

    task automatic reset_dut();
        RB = 1'b0;
        EN = 1'b0;
        DR = 1'b0;
        drive(1'($urandom), 1'($urandom));
        drive(1'($urandom), 1'($urandom));
        drive(1'b0, 1'b0);
        RB = 1'b1;
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RB = 1'b0; EN = 1'b0; DR = 1'b0; I = 1'b0; IB = 1'b0;

        // reset values
        reset_dut();
        chk("rst_do", {24'd0, DO}, 32'd0);
        chk("rst_dv", {31'd0, DV}, 32'd0);
        chk("rst_lock", {31'd0, LOCK}, 32'd0);
        chk("rst_idle", {31'd0, IDLE}, 32'd1);
        chk("rst_err", {31'd0, ERR}, 32'd0);

        // lock and receive two words with the consumer always ready
        reset_dut();
        EN = 1'b1; DR = 1'b1;
        send_bits(8'hA5, 7, 5);
        chk("rx_idle_before", {31'd0, IDLE}, 32'd1);
        send_bits(8'hA5, 4, 4);
        chk("rx_idle_fall", {31'd0, IDLE}, 32'd0);
        send_bits(8'hA5, 3, 0);
        sb_q.push_back(8'h3C);
        send_bits(8'h3C, 7, 6);
        chk("rx_lock_before", {31'd0, LOCK}, 32'd0);
        send_bits(8'h3C, 5, 5);
        chk("rx_lock_rise", {31'd0, LOCK}, 32'd1);
        send_bits(8'h3C, 4, 0);
        sb_q.push_back(8'hF0);
        send_bits(8'hF0, 7, 0);
        send_bits(8'h00, 7, 4);
        chk("rx_err", {31'd0, ERR}, 32'd0);
        chk("rx_sb_empty", sb_q.size(), 32'd0);

        // backpressure: overflow drop, drain, then same-edge replace
        reset_dut();
        EN = 1'b1; DR = 1'b1;
        send_bits(8'hA5, 7, 0);
        DR = 1'b0;
        sb_q.push_back(8'h3C);
        send_bits(8'h3C, 7, 0);
        send_bits(8'h55, 7, 0);
        send_bits(8'h66, 7, 5);
        chk("bp_err", {31'd0, ERR}, 32'd1);
        chk("bp_dv_held", {31'd0, DV}, 32'd1);
        chk("bp_do_held", {24'd0, DO}, 32'h3C);
        send_bits(8'h66, 4, 4);
        DR = 1'b1;
        send_bits(8'h66, 3, 3);
        DR = 1'b0;
        chk("bp_dv_drained", {31'd0, DV}, 32'd0);
        sb_q.push_back(8'h66);
        send_bits(8'h66, 2, 0);
        sb_q.push_back(8'h99);
        send_bits(8'h99, 7, 0);
        send_bits(8'h00, 7, 6);
        DR = 1'b1;
        send_bits(8'h00, 5, 5);
        chk("bp_replace_dv", {31'd0, DV}, 32'd1);
        chk("bp_replace_do", {24'd0, DO}, 32'h99);
        send_bits(8'h00, 4, 4);
        chk("bp_final_dv", {31'd0, DV}, 32'd0);
        chk("bp_err_sticky", {31'd0, ERR}, 32'd1);
        chk("bp_sb_empty", sb_q.size(), 32'd0);

        // framing fault mid-word, then line goes idle
        reset_dut();
        EN = 1'b1; DR = 1'b1;
        send_bits(8'hA5, 7, 0);
        send_bits(8'hA0, 7, 5);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("ff_lock_before", {31'd0, LOCK}, 32'd1);
        drive(1'b0, 1'b0);
        chk("ff_lock_lost", {31'd0, LOCK}, 32'd0);
        chk("ff_err", {31'd0, ERR}, 32'd1);
        chk("ff_hunting", {31'd0, IDLE}, 32'd0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        chk("ff_idle_before", {31'd0, IDLE}, 32'd0);
        drive(1'b0, 1'b0);
        chk("ff_idle", {31'd0, IDLE}, 32'd1);
        chk("ff_err_held", {31'd0, ERR}, 32'd1);
        chk("ff_sb_empty", sb_q.size(), 32'd0);

        // alignment after a 3-bit preamble
        reset_dut();
        EN = 1'b1; DR = 1'b1;
        send_bits(8'h05, 2, 0);
        send_bits(8'hA5, 7, 0);
        sb_q.push_back(8'h81);
        send_bits(8'h81, 7, 6);
        chk("al_lock_before", {31'd0, LOCK}, 32'd0);
        send_bits(8'h81, 5, 5);
        chk("al_lock_rise", {31'd0, LOCK}, 32'd1);
        send_bits(8'h81, 4, 0);
        send_bits(8'h00, 7, 4);
        chk("al_sb_empty", sb_q.size(), 32'd0);

        // an undriven sample inside the sync word must prevent lock
        reset_dut();
        EN = 1'b1; DR = 1'b1;
        send_bits(8'hA5, 7, 1);
        drive(1'b1, 1'b1);
        send_bits(8'hA5, 0, 0);
        send_bits(8'h00, 7, 5);
        chk("nl_lock", {31'd0, LOCK}, 32'd0);
        chk("nl_hunting", {31'd0, IDLE}, 32'd0);
        chk("nl_sb_empty", sb_q.size(), 32'd0);

        // EN=0 mid-word with a held word and a sticky error
        reset_dut();
        EN = 1'b1; DR = 1'b1;
        send_bits(8'hA5, 7, 0);
        DR = 1'b0;
        sb_q.push_back(8'h3C);
        send_bits(8'h3C, 7, 0);
        send_bits(8'h55, 7, 0);
        send_bits(8'h00, 7, 5);
        chk("en_err_pre", {31'd0, ERR}, 32'd1);
        send_bits(8'h00, 4, 4);
        EN = 1'b0;
        send_bits(8'h00, 3, 3);
        chk("en_idle", {31'd0, IDLE}, 32'd1);
        chk("en_lock", {31'd0, LOCK}, 32'd0);
        chk("en_err_clr", {31'd0, ERR}, 32'd0);
        chk("en_dv_kept", {31'd0, DV}, 32'd1);
        chk("en_do_kept", {24'd0, DO}, 32'h3C);

        // reset mid-word while locked and holding an unaccepted word
        EN = 1'b1;
        send_bits(8'hA5, 7, 0);
        send_bits(8'h3C, 7, 5);
        chk("rb_locked", {31'd0, LOCK}, 32'd1);
        drive(1'b1, 1'b0);
        RB = 1'b0;
        sb_q.delete();
        drive(1'b0, 1'b1);
        chk("rb_do", {24'd0, DO}, 32'd0);
        chk("rb_dv", {31'd0, DV}, 32'd0);
        chk("rb_lock", {31'd0, LOCK}, 32'd0);
        chk("rb_idle", {31'd0, IDLE}, 32'd1);
        chk("rb_err", {31'd0, ERR}, 32'd0);
        RB = 1'b1;
        drive(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
